// File: rtl/uart_pkg.sv
// Shared types for the UART receive buffering path.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef logic [UART_BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    ACK
  } rx_hs_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; a write to a full FIFO is accepted only when a
// read frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_wr;
  logic             do_rd;

  // Qualify requests against occupancy; a same-cycle pop makes room for a write.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CntW'(DEPTH));
    do_rd   = rd_en && !empty;
    do_wr   = wr_en && (!full || do_rd);
    count   = count_q;
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_wr && !do_rd)      count_q <= count_q + CntW'(1);
      else if (do_rd && !do_wr) count_q <= count_q - CntW'(1);
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receiver-side byte buffer: synchronises data_ready, closes the receiver
// handshake, and queues bytes for the echo transmit path.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_data_ready,
  output logic                   rx_done,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  input  logic                   overrun_clr,
  output logic                   overrun
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rdy_s;
  rx_hs_state_t           state_q;
  logic                   wr_en;
  logic                   empty;
  logic                   pop;

  assign rdy_s = sync_q[SYNC_STAGES-1];
  assign wr_en = (state_q == CAPTURE);
  assign pop   = tx_valid && tx_ready;

  // Flop chain for the asynchronous, possibly glitchy data_ready flag.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_data_ready};
  end

  // Handshake FSM: one write attempt per data_ready assertion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rx_done <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rx_done <= 1'b0;
          if (rdy_s) state_q <= CAPTURE;
        end
        CAPTURE: begin
          rx_done <= 1'b1;
          state_q <= ACK;
        end
        ACK: begin
          if (!rdy_s) begin
            rx_done <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          rx_done <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst)                            overrun <= 1'b0;
    else if (wr_en && full && !pop)     overrun <= 1'b1;
    else if (overrun_clr)               overrun <= 1'b0;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (rx_data),
    .rd_en   (tx_ready),
    .rd_data (tx_data),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign tx_valid = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_done;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] fifo_count;
  logic       full;
  logic       overrun;
  logic       overrun_clr;

  int tests  = 0;
  int errors = 0;

  uart_rx_fifo #(
    .DEPTH       (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .rx_done       (rx_done),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .fifo_count    (fifo_count),
    .full          (full),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for rx_done to reach the given level, sampled on negedges.
  task automatic wait_done(input logic target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_done === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full receiver-side transfer of one byte; ok reports handshake completion.
  task automatic send_byte(input logic [7:0] d, output bit ok);
    bit ok1, ok2;
    step();
    rx_data       = d;
    rx_data_ready = 1'b1;
    wait_done(1'b1, ok1);
    step();
    rx_data_ready = 1'b0;
    wait_done(1'b0, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_data = 8'h00; rx_data_ready = 1'b0; tx_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({rx_done, tx_valid, full, overrun} !== 4'b0000 || fifo_count !== 5'd0
        || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: done=%b valid=%b full=%b ovr=%b cnt=%0d data=%h, want all 0",
               rx_done, tx_valid, full, overrun, fifo_count, tx_data);
    end
  endtask

  task automatic test_single_byte();
    step();
    rx_data = 8'hA5; rx_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rx_done !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: done=%b valid=%b, want 0 0", rx_done, tx_valid);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (rx_done !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5 || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL single_capture: done=%b valid=%b data=%h cnt=%0d, want 1 1 a5 1",
               rx_done, tx_valid, tx_data, fifo_count);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (rx_done !== 1'b1 || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL single_hold: done=%b cnt=%0d, want 1 1", rx_done, fifo_count);
    end
    step();
    rx_data_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rx_done !== 1'b1) begin
      errors++;
      $display("FAIL single_ack_tail: done=%b, want 1", rx_done);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (rx_done !== 1'b0) begin
      errors++;
      $display("FAIL single_release: done=%b, want 0", rx_done);
    end
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (tx_valid !== 1'b0 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL single_pop: valid=%b cnt=%0d, want 0 0", tx_valid, fifo_count);
    end
  endtask

  task automatic test_burst_order();
    bit ok;
    bit all_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), ok);
      all_ok &= ok;
    end
    tests++;
    if (!all_ok || full !== 1'b1 || fifo_count !== 5'd16) begin
      errors++;
      $display("FAIL burst_fill: hs_ok=%b full=%b cnt=%0d, want 1 1 16", all_ok, full, fifo_count);
    end
    step();
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        errors++;
        $display("FAIL burst_drain[%0d]: valid=%b data=%h, want 1 %h", i, tx_valid, tx_data, 8'(i));
      end
    end
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (fifo_count !== 5'd0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL burst_empty: cnt=%0d valid=%b, want 0 0", fifo_count, tx_valid);
    end
    send_byte(8'h55, ok);
    tests++;
    if (!ok || tx_valid !== 1'b1 || tx_data !== 8'h55 || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL burst_wrap: hs_ok=%b valid=%b data=%h cnt=%0d, want 1 1 55 1",
               ok, tx_valid, tx_data, fifo_count);
    end
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
  endtask

  task automatic test_overrun();
    bit ok;
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), ok);
    send_byte(8'hEE, ok);
    tests++;
    if (!ok || overrun !== 1'b1 || fifo_count !== 5'd16) begin
      errors++;
      $display("FAIL overrun_set: hs_ok=%b ovr=%b cnt=%0d, want 1 1 16", ok, overrun, fifo_count);
    end
    step();
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests++;
      if (tx_data !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL overrun_drain[%0d]: data=%h, want %h", i, tx_data, 8'h10 + 8'(i));
      end
    end
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (fifo_count !== 5'd0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: cnt=%0d ovr=%b, want 0 1", fifo_count, overrun);
    end
    step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr: ovr=%b, want 0", overrun);
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), ok);
    step();
    rx_data = 8'h77; rx_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (fifo_count !== 5'd16 || overrun !== 1'b0 || rx_done !== 1'b1 || tx_data !== 8'h21) begin
      errors++;
      $display("FAIL full_pop: cnt=%0d ovr=%b done=%b data=%h, want 16 0 1 21",
               fifo_count, overrun, rx_done, tx_data);
    end
    step();
    rx_data_ready = 1'b0;
    wait_done(1'b0, ok);
    tests++;
    if (!ok) begin
      errors++;
      $display("FAIL full_pop_release: rx_done stuck at %b, want 0", rx_done);
    end
    step();
    tx_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      @(negedge clk);
      tests++;
      if (tx_data !== ((i == 16) ? 8'h77 : 8'h20 + 8'(i))) begin
        errors++;
        $display("FAIL full_pop_drain[%0d]: data=%h, want %h", i, tx_data,
                 (i == 16) ? 8'h77 : 8'h20 + 8'(i));
      end
    end
    step();
    tx_ready = 1'b0;
  endtask

  task automatic test_held_level();
    bit ok;
    step();
    rx_data = 8'h3C; rx_data_ready = 1'b1;
    repeat (50) step();
    @(negedge clk);
    tests++;
    if (fifo_count !== 5'd1 || rx_done !== 1'b1) begin
      errors++;
      $display("FAIL held_level: cnt=%0d done=%b, want 1 1", fifo_count, rx_done);
    end
    step();
    rx_data_ready = 1'b0;
    wait_done(1'b0, ok);
    repeat (3) @(negedge clk);
    tests++;
    if (!ok || fifo_count !== 5'd1 || tx_data !== 8'h3C) begin
      errors++;
      $display("FAIL held_release: hs_ok=%b cnt=%0d data=%h, want 1 1 3c", ok, fifo_count, tx_data);
    end
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_byte(8'h01, ok);
    send_byte(8'h02, ok);
    step();
    rx_data = 8'h03; rx_data_ready = 1'b1;
    wait_done(1'b1, ok);
    tests++;
    if (!ok || fifo_count !== 5'd3) begin
      errors++;
      $display("FAIL reset_mid_setup: hs_ok=%b cnt=%0d, want 1 3", ok, fifo_count);
    end
    step();
    rst = 1'b1; rx_data_ready = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({rx_done, tx_valid, overrun, full} !== 4'b0000 || fifo_count !== 5'd0
        || tx_data !== 8'h00 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_mid: done=%b valid=%b ovr=%b full=%b cnt=%0d data=%h idle=%b, want 0s idle=1",
               rx_done, tx_valid, overrun, full, fifo_count, tx_data, dut.state_q == IDLE);
    end
    repeat (6) @(negedge clk);
    tests++;
    if (rx_done !== 1'b0 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_quiet: done=%b cnt=%0d, want 0 0", rx_done, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst_order();
    test_overrun();
    test_full_pop();
    test_held_level();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
